// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs the instruction-fetch handshake and selects the next PC
// (sequential, relative branch, call/return through a return-address stack) with stall hold.
module fetch_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             fetch_req,
    output logic [ADDR_W-1:0]                fetch_addr,
    input  logic                             fetch_ack,
    output logic                             instr_valid,
    input  logic [1:0]                       op,
    input  logic                             branch_taken,
    input  logic [ADDR_W-1:0]                jump_offset,
    input  logic                             stall,
    output logic [ADDR_W-1:0]                pc,
    output logic [$clog2(STACK_DEPTH):0]     sp,
    output logic                             fault
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [1:0] OP_BRANCH = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11;

    typedef enum logic [1:0] {S_FETCH, S_STALL, S_FAULT} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;
    logic              r_fault;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [1:0]        r_hold_op;
    logic              r_hold_taken;
    logic [ADDR_W-1:0] r_hold_off;

    logic [1:0]        w_op;
    logic              w_taken;
    logic [ADDR_W-1:0] w_off, w_seq, w_tgt, w_top, w_next;
    logic [SP_W-1:0]   w_sp_m1;
    logic              w_capture, w_apply, w_ovf, w_unf;

    assign fetch_req   = r_state == S_FETCH;
    assign fetch_addr  = r_pc;
    assign pc          = r_pc;
    assign sp          = r_sp;
    assign fault       = r_fault;
    assign instr_valid = fetch_req & fetch_ack;

    // Leaving STALL replays the instruction captured in the hold registers.
    always_comb begin
        w_op      = r_state == S_STALL ? r_hold_op    : op;
        w_taken   = r_state == S_STALL ? r_hold_taken : branch_taken;
        w_off     = r_state == S_STALL ? r_hold_off   : jump_offset;
        w_seq     = r_pc + 1'b1;
        w_tgt     = w_seq + w_off;
        w_sp_m1   = r_sp - 1'b1;
        w_top     = r_stack[w_sp_m1[IDX_W-1:0]];
        w_next    = w_op == OP_RET ? w_top :
                    (w_op == OP_CALL || (w_op == OP_BRANCH && w_taken)) ? w_tgt : w_seq;
        w_capture = instr_valid && stall;
        w_apply   = !stall && (instr_valid || r_state == S_STALL);
        w_ovf     = w_op == OP_CALL && r_sp == SP_W'(STACK_DEPTH);
        w_unf     = w_op == OP_RET && r_sp == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_sp         <= '0;
            r_fault      <= 1'b0;
            r_hold_op    <= '0;
            r_hold_taken <= 1'b0;
            r_hold_off   <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else if (w_capture) begin
            r_hold_op    <= op;
            r_hold_taken <= branch_taken;
            r_hold_off   <= jump_offset;
            r_state      <= S_STALL;
        end else if (w_apply) begin
            if (w_ovf || w_unf) begin
                r_fault <= 1'b1;
                r_state <= S_FAULT;
            end else begin
                r_pc    <= w_next;
                r_state <= S_FETCH;
                if (w_op == OP_CALL) begin
                    r_stack[r_sp[IDX_W-1:0]] <= w_seq;
                    r_sp <= r_sp + 1'b1;
                end else if (w_op == OP_RET) begin
                    r_sp <= w_sp_m1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_req, instr_valid, fault;
    logic [7:0] fetch_addr, pc;
    logic       fetch_ack = 1'b0;
    logic [1:0] op = 2'b00;
    logic       branch_taken = 1'b0;
    logic [7:0] jump_offset = 8'h00;
    logic       stall = 1'b0;
    logic [2:0] sp;
    int         tests = 0;
    int         fails = 0;

    localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, CALL = 2'b10, RET = 2'b11;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .instr_valid(instr_valid), .op(op),
        .branch_taken(branch_taken), .jump_offset(jump_offset), .stall(stall),
        .pc(pc), .sp(sp), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic a, input logic [1:0] o, input logic t,
                         input logic [7:0] f, input logic s);
        fetch_ack = a; op = o; branch_taken = t; jump_offset = f; stall = s;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [1:0] o, input logic t, input logic [7:0] f);
        drive(1'b1, o, t, f, 1'b0);
        tick();
    endtask

    task automatic do_reset;
        drive(1'b0, SEQ, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        tick();
        do_reset();
        tests++; if (pc !== 8'h00) begin fails++; $display("FAIL reset_pc got %h exp 00", pc); end
        tests++; if (sp !== 3'd0) begin fails++; $display("FAIL reset_sp got %0d exp 0", sp); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b exp 0", fault); end
        tests++; if (fetch_req !== 1'b1) begin fails++; $display("FAIL reset_req got %b exp 1", fetch_req); end
        tests++; if (fetch_addr !== 8'h00) begin fails++; $display("FAIL reset_addr got %h exp 00", fetch_addr); end
    endtask

    task automatic test_seq;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, SEQ, 1'b0, 8'h00, 1'b0);
            #1;
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL seq_valid got %b exp 1", instr_valid); end
            tick();
            tests++; if (pc !== 8'(i)) begin fails++; $display("FAIL seq_pc got %h exp %h", pc, 8'(i)); end
            tests++; if (fetch_req !== 1'b1) begin fails++; $display("FAIL seq_req got %b exp 1", fetch_req); end
        end
    endtask

    task automatic test_branch;
        fetch(SEQ, 1'b0, 8'h00);
        fetch(SEQ, 1'b0, 8'h00);
        tests++; if (pc !== 8'h05) begin fails++; $display("FAIL br_start got %h exp 05", pc); end
        fetch(BR, 1'b1, 8'h03);
        tests++; if (pc !== 8'h09) begin fails++; $display("FAIL br_fwd got %h exp 09", pc); end
        fetch(BR, 1'b1, 8'hFC);
        tests++; if (pc !== 8'h06) begin fails++; $display("FAIL br_back got %h exp 06", pc); end
        fetch(BR, 1'b0, 8'h40);
        tests++; if (pc !== 8'h07) begin fails++; $display("FAIL br_not_taken got %h exp 07", pc); end
    endtask

    task automatic test_call_ret;
        fetch(BR, 1'b1, 8'h08);
        tests++; if (pc !== 8'h10) begin fails++; $display("FAIL call_start got %h exp 10", pc); end
        fetch(CALL, 1'b0, 8'h20);
        tests++; if (pc !== 8'h31 || sp !== 3'd1) begin fails++; $display("FAIL call_pc_sp got %h/%0d exp 31/1", pc, sp); end
        fetch(RET, 1'b0, 8'h55);
        tests++; if (pc !== 8'h11 || sp !== 3'd0) begin fails++; $display("FAIL ret_pc_sp got %h/%0d exp 11/0", pc, sp); end
        for (int i = 0; i < 4; i++) fetch(CALL, 1'b0, 8'h00);
        tests++; if (pc !== 8'h15 || sp !== 3'd4) begin fails++; $display("FAIL nest_call got %h/%0d exp 15/4", pc, sp); end
        for (int i = 0; i < 4; i++) begin
            fetch(RET, 1'b0, 8'h00);
            tests++;
            if (pc !== 8'(8'h15 - i) || sp !== 3'(3 - i)) begin
                fails++; $display("FAIL nest_ret got %h/%0d exp %h/%0d", pc, sp, 8'(8'h15 - i), 3'(3 - i));
            end
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) fetch(CALL, 1'b0, 8'h00);
        tests++; if (pc !== 8'h16 || sp !== 3'd4) begin fails++; $display("FAIL ovf_pre got %h/%0d exp 16/4", pc, sp); end
        fetch(CALL, 1'b0, 8'h00);
        tests++; if (fault !== 1'b1) begin fails++; $display("FAIL ovf_fault got %b exp 1", fault); end
        tests++; if (pc !== 8'h16 || sp !== 3'd4) begin fails++; $display("FAIL ovf_frozen got %h/%0d exp 16/4", pc, sp); end
        tests++; if (fetch_req !== 1'b0) begin fails++; $display("FAIL ovf_req got %b exp 0", fetch_req); end
        drive(1'b1, RET, 1'b0, 8'h00, 1'b0);
        #1;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fault_valid got %b exp 0", instr_valid); end
        tick();
        tests++; if (pc !== 8'h16 || sp !== 3'd4 || fault !== 1'b1 || fetch_req !== 1'b0) begin
            fails++; $display("FAIL fault_stuck got pc %h sp %0d fault %b req %b exp 16 4 1 0", pc, sp, fault, fetch_req);
        end
        do_reset();
        tests++; if (fault !== 1'b0 || pc !== 8'h00 || sp !== 3'd0) begin
            fails++; $display("FAIL fault_clear got fault %b pc %h sp %0d exp 0 00 0", fault, pc, sp);
        end
    endtask

    task automatic test_underflow;
        fetch(RET, 1'b0, 8'h00);
        tests++; if (fault !== 1'b1 || pc !== 8'h00 || fetch_req !== 1'b0) begin
            fails++; $display("FAIL unf got fault %b pc %h req %b exp 1 00 0", fault, pc, fetch_req);
        end
        do_reset();
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++) fetch(SEQ, 1'b0, 8'h00);
        drive(1'b1, BR, 1'b1, 8'h02, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++; if (pc !== 8'h04 || fetch_req !== 1'b0) begin
                fails++; $display("FAIL stall_hold got pc %h req %b exp 04 0", pc, fetch_req);
            end
            drive(1'b1, SEQ, 1'b0, 8'h77, 1'b1);
            #1;
            tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stall_valid got %b exp 0", instr_valid); end
            if (i < 2) tick();
        end
        drive(1'b1, SEQ, 1'b0, 8'h77, 1'b0);
        tick();
        tests++; if (pc !== 8'h07 || fetch_req !== 1'b1) begin
            fails++; $display("FAIL stall_release got pc %h req %b exp 07 1", pc, fetch_req);
        end
    endtask

    task automatic test_wrap;
        fetch(BR, 1'b1, 8'hF7);
        tests++; if (pc !== 8'hFF) begin fails++; $display("FAIL wrap_pre got %h exp FF", pc); end
        fetch(SEQ, 1'b0, 8'h00);
        tests++; if (pc !== 8'h00) begin fails++; $display("FAIL wrap_seq got %h exp 00", pc); end
        fetch(BR, 1'b1, 8'hFD);
        tests++; if (pc !== 8'hFE) begin fails++; $display("FAIL wrap_neg got %h exp FE", pc); end
    endtask

    task automatic test_no_ack;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, CALL, 1'b1, 8'h10, i[0]);
            #1;
            tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL noack_valid got %b exp 0", instr_valid); end
            tick();
            tests++; if (pc !== 8'hFE || fetch_addr !== 8'hFE || fetch_req !== 1'b1) begin
                fails++; $display("FAIL noack_hold got pc %h addr %h req %b exp FE FE 1", pc, fetch_addr, fetch_req);
            end
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, BR, 1'b1, 8'h30, 1'b1);
        tick();
        tests++; if (fetch_req !== 1'b0) begin fails++; $display("FAIL ares_in_stall got %b exp 0", fetch_req); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (pc !== 8'h00 || fetch_req !== 1'b1) begin
            fails++; $display("FAIL ares_async got pc %h req %b exp 00 1", pc, fetch_req);
        end
        drive(1'b1, SEQ, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        tick();
        tests++; if (pc !== 8'h01) begin fails++; $display("FAIL ares_resume got %h exp 01", pc); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_stall();
        test_wrap();
        test_no_ack();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
